// File: rtl/multi_stepper_pkg.sv
// Shared mode and direction encodings for the multi-channel stepped counter.
package multi_stepper_pkg;
   localparam logic [1:0] MODE_WRAP_UP   = 2'b00;
   localparam logic [1:0] MODE_WRAP_DOWN = 2'b01;
   localparam logic [1:0] MODE_SAT_UP    = 2'b10;
   localparam logic [1:0] MODE_BOUNCE    = 2'b11;
   localparam logic       DIR_UP         = 1'b0;
   localparam logic       DIR_DOWN       = 1'b1;
endpackage

// File: rtl/multi_stepper_lane.sv
// One counter channel: value, bounce direction and wrap/limit event registers.
module stepper_lane
   import multi_stepper_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_int,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [SW-1:0]    step,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] ctr,
   output logic             evt
);
   localparam logic [WIDTH:0] MAX_EXT = {1'b0, {WIDTH{1'b1}}};

   logic [WIDTH-1:0] ctr_q, ctr_d;
   logic             dir_q, dir_d;
   logic             evt_q, evt_d;
   logic [WIDTH-1:0] step_ext;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;

   assign step_ext = WIDTH'(step);
   assign sum      = {1'b0, ctr_q} + {1'b0, step_ext};
   assign diff     = {1'b0, ctr_q} - {1'b0, step_ext};

   // Next-state: load wins over tick; a zero step leaves everything untouched.
   always_comb begin
      ctr_d = ctr_q;
      dir_d = dir_q;
      evt_d = 1'b0;
      if (load) begin
         ctr_d = load_val;
         dir_d = DIR_UP;
      end else if (tick_int && (step != {SW{1'b0}})) begin
         case (mode)
            MODE_WRAP_UP: begin
               ctr_d = sum[WIDTH-1:0];
               evt_d = sum[WIDTH];
            end
            MODE_WRAP_DOWN: begin
               ctr_d = diff[WIDTH-1:0];
               evt_d = diff[WIDTH];
            end
            MODE_SAT_UP: begin
               if (sum >= MAX_EXT) begin
                  ctr_d = MAX_EXT[WIDTH-1:0];
                  evt_d = ({1'b0, ctr_q} != MAX_EXT);
               end else begin
                  ctr_d = sum[WIDTH-1:0];
               end
            end
            MODE_BOUNCE: begin
               if (dir_q == DIR_UP) begin
                  if (sum >= MAX_EXT) begin
                     ctr_d = MAX_EXT[WIDTH-1:0];
                     dir_d = DIR_DOWN;
                     evt_d = 1'b1;
                  end else begin
                     ctr_d = sum[WIDTH-1:0];
                  end
               end else begin
                  if (ctr_q <= step_ext) begin
                     ctr_d = {WIDTH{1'b0}};
                     dir_d = DIR_UP;
                     evt_d = 1'b1;
                  end else begin
                     ctr_d = diff[WIDTH-1:0];
                  end
               end
            end
            default: begin
               ctr_d = ctr_q;
            end
         endcase
      end else begin
         ctr_d = ctr_q;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctr_q <= {WIDTH{1'b0}};
         dir_q <= DIR_UP;
         evt_q <= 1'b0;
      end else begin
         ctr_q <= ctr_d;
         dir_q <= dir_d;
         evt_q <= evt_d;
      end
   end

   assign ctr = ctr_q;
   assign evt = evt_q;
endmodule

// File: rtl/multi_stepper.sv
// NCH stepped counters advanced together by a self-contained periodic tick
// prescaler running from the system clock.
module multi_stepper
   import multi_stepper_pkg::*;
#(
   parameter int CLK_HZ    = 12_000_000,
   parameter int PERIOD_MS = 1000,
   parameter int NCH       = 2,
   parameter int WIDTH     = 8,
   parameter int SW        = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [NCH*SW-1:0]    step,
   input  logic [NCH*2-1:0]     mode,
   input  logic [NCH-1:0]       load,
   input  logic [NCH*WIDTH-1:0] load_val,
   output logic [NCH*WIDTH-1:0] ctr,
   output logic [NCH-1:0]       evt,
   output logic                 tick
);
   localparam int DIV = (CLK_HZ / 1000) * PERIOD_MS;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);

   if (DIV < 1) begin : g_div_check
      $error("multi_stepper: tick divider must be at least 1");
   end

   logic [PW-1:0] pcnt_q, pcnt_d;
   logic          tick_q, tick_d;
   logic          tick_int;

   assign tick_int = en && (pcnt_q == PCNT_LAST);

   // Prescaler: counts while enabled, wraps on the tick cycle, holds otherwise.
   always_comb begin
      pcnt_d = pcnt_q;
      tick_d = tick_int;
      if (tick_int) begin
         pcnt_d = {PW{1'b0}};
      end else if (en) begin
         pcnt_d = pcnt_q + PW'(1'b1);
      end else begin
         pcnt_d = pcnt_q;
      end
   end

   // Prescaler and tick registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt_q <= {PW{1'b0}};
         tick_q <= 1'b0;
      end else begin
         pcnt_q <= pcnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

   for (genvar i = 0; i < NCH; i++) begin : g_lane
      stepper_lane #(
         .WIDTH(WIDTH),
         .SW   (SW)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .tick_int(tick_int),
         .load    (load[i]),
         .load_val(load_val[i*WIDTH +: WIDTH]),
         .step    (step[i*SW +: SW]),
         .mode    (mode[i*2 +: 2]),
         .ctr     (ctr[i*WIDTH +: WIDTH]),
         .evt     (evt[i])
      );
   end
endmodule

// File: doc/multi_stepper.md
Name: multi_stepper

Overview:
- Parametrised successor to the single 8-bit stepped counter: NCH independent counters of WIDTH bits, each advanced by its own step on a shared periodic tick.
- Per-channel mode selects wrap-up, wrap-down, saturate-up or bounce; per-channel synchronous load; per-channel wrap/limit event pulse.
- Sits between the DIP/step sources and display sinks (led8, RGB logic). Carries its own prescaler so it needs only the system clock.

Parameters:
- CLK_HZ, 12_000_000, system clock frequency in Hz.
- PERIOD_MS, 1000, tick period in ms.
- NCH, 2, number of channels (>=1).
- WIDTH, 8, counter width per channel (>=2).
- SW, 4, step width per channel (1..WIDTH); step is zero-extended to WIDTH.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  prescaler enable; low freezes the prescaler, so no ticks occur
- step  in  NCH*SW  per-channel step; channel i at [i*SW +: SW]
- mode  in  NCH*2  per-channel mode; channel i at [i*2 +: 2]
- load  in  NCH  per-channel synchronous load strobe
- load_val  in  NCH*WIDTH  per-channel load value
- ctr  out  NCH*WIDTH  per-channel counter value, registered
- evt  out  NCH  per-channel one-cycle wrap/limit pulse, registered
- tick  out  1  one-cycle pulse, coincident with the counter update it caused

Behaviour:
- DIV = (CLK_HZ/1000)*PERIOD_MS, computed at elaboration. DIV < 1 is an elaboration error.
- Prescaler pcnt runs 0..DIV-1 while en=1. tick_int = en && pcnt==DIV-1, and pcnt returns to 0 on the same edge. With en=0, pcnt holds.
- Reset (rst=1 at an edge) sets: pcnt=0, all ctr=0, all dir=UP, evt=0, tick=0. Reset overrides load and tick_int. A mid-period reset restarts the full DIV count.
- Latency: on the edge where tick_int=1, ctr takes its new value and the tick and evt registers go high. All three are visible together for exactly one cycle.
- Priority per channel: rst > load > tick_int.
- load[i]=1: ctr_i<=load_val_i, dir_i<=UP, evt_i<=0. A coincident tick is ignored for that channel only.
- step_i==0 on a tick: no change, evt_i=0, dir_i unchanged, in every mode.
- MAX = 2^WIDTH-1. Arithmetic uses a WIDTH+1-bit intermediate.
- Mode 00 WRAP_UP: ctr+=step mod 2^WIDTH. evt=1 iff carry out.
- Mode 01 WRAP_DOWN: ctr-=step mod 2^WIDTH. evt=1 iff borrow.
- Mode 10 SAT_UP: ctr=min(ctr+step, MAX). evt=1 iff ctr<MAX before the update and ctr==MAX after it, i.e. only on first arrival. Once at MAX, further ticks hold and give evt=0.
- Mode 11 BOUNCE, dir=UP: if ctr+step >= MAX then ctr=MAX, dir=DOWN, evt=1; otherwise ctr+=step.
- Mode 11 BOUNCE, dir=DOWN: if ctr <= step then ctr=0, dir=UP, evt=1; otherwise ctr-=step.
- dir is internal and is used only in BOUNCE. It is retained across mode changes.
- Mode and step are sampled on the tick edge. A change between ticks takes effect at the next tick.
- Outside tick edges and load edges, evt=0 and tick=0.

Decomposition:
- Package multi_stepper_pkg holds: mode localparams MODE_WRAP_UP=2'b00, MODE_WRAP_DOWN=2'b01, MODE_SAT_UP=2'b10, MODE_BOUNCE=2'b11; and DIR_UP=1'b0, DIR_DOWN=1'b1.
- Sub-module stepper_lane (params WIDTH, SW) holds one channel's ctr, dir and evt registers.
  - Inputs: clk, rst, tick_int, load, load_val, step, mode.
  - The top generates NCH instances and owns the prescaler and the tick register.

Test Plan:
- CLK_HZ=1000, PERIOD_MS=4 (DIV=4), NCH=2, WIDTH=8, SW=4.
- Release rst, en=1: tick pulses every 4th cycle, first one 4 cycles after reset release. Holding en=0 for 6 cycles delays the next tick by exactly 6 cycles.
- Ch0 WRAP_UP, step=5, load 250 -> ctr 250,255,4 (evt=1 with ctr=4),9. Ch1 WRAP_DOWN, step=3, load 4 -> 1, 254 (evt=1), 251.
- SAT_UP, step=15, load 240 -> 255 with evt=1. Next tick: 255 with evt=0. step=0 on any mode: ctr unchanged, evt=0.
- BOUNCE, step=7, load 250 -> 255 (evt, dir DOWN), 248, 241. Load 5 (dir forced UP) then ticks -> 12, 19. Switch to step=12, dir DOWN reached via 255 -> ... ->0 with evt when ctr<=12.
- load asserted on a tick cycle: ctr=load_val, evt=0, and the other channel still updates. rst asserted mid-period with ctr=77: ctr=0, tick low, and the next tick arrives DIV cycles after rst drops.
